// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Shares the SDRAM controller's single AXI-style slave port between
//            NUM_PORTS requesters, one transaction at a time. Round-robin by
//            default; define SDRAM_ARB_FIXED_PRIO_EN for lowest-index-wins.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 2
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_axi_awaddr,
    input  logic [NUM_PORTS-1:0]             s_axi_awvalid,
    output logic [NUM_PORTS-1:0]             s_axi_awready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axi_wdata,
    input  logic [NUM_PORTS-1:0]             s_axi_wvalid,
    output logic [NUM_PORTS-1:0]             s_axi_wready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic [NUM_PORTS-1:0]             s_axi_arvalid,
    output logic [NUM_PORTS-1:0]             s_axi_arready,
    output logic [DATA_WIDTH-1:0]            s_axi_rdata,
    output logic [NUM_PORTS-1:0]             s_axi_rvalid,
    input  logic [NUM_PORTS-1:0]             s_axi_rready,

    output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
    output logic                             m_axi_awvalid,
    input  logic                             m_axi_awready,
    output logic [DATA_WIDTH-1:0]            m_axi_wdata,
    output logic                             m_axi_wvalid,
    input  logic                             m_axi_wready,
    output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,
    input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic                             m_axi_rvalid,
    output logic                             m_axi_rready,

    output logic [NUM_PORTS-1:0]             grant,
    output logic                             busy
);

    localparam int c_idx_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_rdata = 2'd2;

    logic [1:0]            r_state;
    logic [NUM_PORTS-1:0]  r_grant;
    logic [c_idx_w-1:0]    r_gidx;
    logic                  r_is_read;

    logic [NUM_PORTS-1:0]  w_req;
    logic                  w_win_valid;
    logic [c_idx_w-1:0]    w_win_idx;
    logic [NUM_PORTS-1:0]  w_win_onehot;
    logic                  w_win_is_read;
    logic                  w_wr_fire;
    logic                  w_ar_fire;
    logic                  w_r_fire;

`ifndef SDRAM_ARB_FIXED_PRIO_EN
    logic [c_idx_w-1:0]    r_last;
    logic [c_idx_w:0]      w_cand;
`endif

    // A lone awvalid is not a request: the write needs its data beat too.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req
            assign w_req[gi] = s_axi_arvalid[gi] | (s_axi_awvalid[gi] & s_axi_wvalid[gi]);
        end
    endgenerate

    always_comb begin
        w_win_valid = |w_req;
        w_win_idx   = '0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win_idx = c_idx_w'(i);
            end
        end
`else
        // Walk from farthest to nearest so the port closest after r_last wins.
        w_cand = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_cand = {1'b0, r_last} + (c_idx_w + 1)'(k);
            if (w_cand >= (c_idx_w + 1)'(NUM_PORTS)) begin
                w_cand = w_cand - (c_idx_w + 1)'(NUM_PORTS);
            end
            if (w_req[w_cand[c_idx_w-1:0]]) begin
                w_win_idx = w_cand[c_idx_w-1:0];
            end
        end
`endif
    end

    assign w_win_onehot  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_win_idx;
    assign w_win_is_read = |(s_axi_arvalid & w_win_onehot);

    assign w_wr_fire = (r_state == c_st_issue) && !r_is_read && m_axi_awready && m_axi_wready;
    assign w_ar_fire = (r_state == c_st_issue) && r_is_read && m_axi_arready;
    assign w_r_fire  = (r_state == c_st_rdata) && m_axi_rvalid && (|(s_axi_rready & r_grant));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_is_read <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            r_last    <= c_idx_w'(NUM_PORTS - 1);
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_win_valid) begin
                        r_grant   <= w_win_onehot;
                        r_gidx    <= w_win_idx;
                        r_is_read <= w_win_is_read;
                        r_state   <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    if (w_wr_fire) begin
                        r_grant <= '0;
                        r_state <= c_st_idle;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                        r_last  <= r_gidx;
`endif
                    end else if (w_ar_fire) begin
                        r_state <= c_st_rdata;
                    end
                end
                c_st_rdata: begin
                    if (w_r_fire) begin
                        r_grant <= '0;
                        r_state <= c_st_idle;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                        r_last  <= r_gidx;
`endif
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Payload muxes are harmless when idle: every valid is gated by state.
    assign m_axi_awaddr  = s_axi_awaddr[int'(r_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_axi_wdata   = s_axi_wdata[int'(r_gidx)*DATA_WIDTH +: DATA_WIDTH];
    assign m_axi_araddr  = s_axi_araddr[int'(r_gidx)*ADDR_WIDTH +: ADDR_WIDTH];

    assign m_axi_awvalid = (r_state == c_st_issue) && !r_is_read;
    assign m_axi_wvalid  = (r_state == c_st_issue) && !r_is_read;
    assign m_axi_arvalid = (r_state == c_st_issue) && r_is_read;
    assign m_axi_rready  = (r_state == c_st_rdata) && (|(s_axi_rready & r_grant));

    assign s_axi_awready = r_grant & {NUM_PORTS{w_wr_fire}};
    assign s_axi_wready  = r_grant & {NUM_PORTS{w_wr_fire}};
    assign s_axi_arready = r_grant & {NUM_PORTS{w_ar_fire}};
    assign s_axi_rvalid  = r_grant & {NUM_PORTS{(r_state == c_st_rdata) && m_axi_rvalid}};
    assign s_axi_rdata   = m_axi_rdata;

    assign grant = r_grant;
    assign busy  = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Purpose  : Self-checking bench for sdram_port_arbiter: vector table, directed
//            corner sequences and random traffic against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 25;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;

    logic [NP*AW-1:0] s_axi_awaddr, s_axi_araddr;
    logic [NP*DW-1:0] s_axi_wdata;
    logic [NP-1:0]    s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [NP-1:0]    s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
    logic [DW-1:0]    s_axi_rdata;
    logic [AW-1:0]    m_axi_awaddr, m_axi_araddr;
    logic [DW-1:0]    m_axi_wdata, m_axi_rdata;
    logic             m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic             m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic [NP-1:0]    grant;
    logic             busy;

    sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        s_axi_awaddr  = '0; s_axi_araddr = '0; s_axi_wdata = '0;
        s_axi_awvalid = '0; s_axi_wvalid = '0; s_axi_arvalid = '0; s_axi_rready = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0; m_axi_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [NP-1:0] ar, aw, w;
        logic [NP-1:0] exp_grant;
        logic          exp_rd, exp_wr;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] ar, aw, w, g, input logic rd, wr);
        vec_t v;
        v.ar = ar; v.aw = aw; v.w = w; v.exp_grant = g; v.exp_rd = rd; v.exp_wr = wr;
        return v;
    endfunction

    // Random-traffic requester state and transaction-level reference model
    logic [AW-1:0] p_araddr [NP];
    logic [AW-1:0] p_awaddr [NP];
    logic [DW-1:0] p_wdata  [NP];
    logic          pend_rd  [NP];
    logic          pend_wr  [NP];
    int            wdly     [NP];
    logic [NP-1:0] hs_ar, hs_aw;

    int   mo_owner;
    logic mo_read, mo_data;
    int   mo_last;

    logic [NP-1:0] e_grant, e_awr, e_ar, e_rv, req;
    logic          e_busy, e_awv, e_arv, e_rr;
    int            win;

    vec_t          vecs [11];
    logic [NP-1:0] order [4];
    logic [NP-1:0] exp_order [4];
    logic [NP-1:0] op_grant [2];
    int            op_kind [2];
    int            n_got;
    logic          drop_ar, drop_aw;
    logic [AW-1:0] exp_addr;

    initial begin
        vecs[0]  = mk(2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
        vecs[1]  = mk(2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0);
        vecs[2]  = mk(2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
        vecs[3]  = mk(2'b00, 2'b11, 2'b11, 2'b01, 1'b0, 1'b1);
        vecs[4]  = mk(2'b00, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1);
        vecs[5]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        vecs[6]  = mk(2'b10, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1);
        vecs[7]  = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0);
        vecs[8]  = mk(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
        vecs[9]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        vecs[10] = mk(2'b00, 2'b10, 2'b11, 2'b10, 1'b0, 1'b1);

        // Reset state, asynchronous: visible before any clock edge
        reset = 1'b1;
        idle_inputs();
        #2;
        check("reset_grant", grant, 2'b00);
        check("reset_busy", busy, 1'b0);
        check("reset_mvalids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready}, 4'b0);
        check("reset_sready", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_rvalid}, 8'b0);

        // Vector table: one arbitration decision from a fresh reset
        for (int i = 0; i < 11; i++) begin
            do_reset();
            s_axi_araddr = {25'h0000B11, 25'h0000A00};
            s_axi_awaddr = {25'h0000D11, 25'h0000C00};
            s_axi_arvalid = vecs[i].ar;
            s_axi_awvalid = vecs[i].aw;
            s_axi_wvalid  = vecs[i].w;
            #1;
            check($sformatf("vec%0d_pre_busy", i), busy, 1'b0);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
            check($sformatf("vec%0d_busy", i), busy, |vecs[i].exp_grant);
            check($sformatf("vec%0d_mvalid", i), {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid},
                  {vecs[i].exp_rd, vecs[i].exp_wr, vecs[i].exp_wr});
            if (vecs[i].exp_rd) begin
                exp_addr = (vecs[i].exp_grant == 2'b01) ? 25'h0000A00 : 25'h0000B11;
                check($sformatf("vec%0d_araddr", i), m_axi_araddr, exp_addr);
            end
            if (vecs[i].exp_wr) begin
                exp_addr = (vecs[i].exp_grant == 2'b01) ? 25'h0000C00 : 25'h0000D11;
                check($sformatf("vec%0d_awaddr", i), m_axi_awaddr, exp_addr);
            end
        end

        // Single write from port 1
        do_reset();
        s_axi_awaddr[AW +: AW] = 25'h0000123;
        s_axi_wdata[DW +: DW]  = 16'hBEEF;
        s_axi_awvalid = 2'b10; s_axi_wvalid = 2'b10;
        @(negedge clk); #1;
        check("wr_grant", grant, 2'b10);
        check("wr_awaddr", m_axi_awaddr, 25'h0000123);
        check("wr_wdata", m_axi_wdata, 16'hBEEF);
        check("wr_stall_ready", {s_axi_awready, s_axi_wready}, 4'b0000);
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        #1;
        check("wr_ready_pulse", {s_axi_awready, s_axi_wready}, 4'b1010);
        @(negedge clk);
        s_axi_awvalid = '0; s_axi_wvalid = '0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        #1;
        check("wr_done_busy", busy, 1'b0);

        // Single read from port 0
        do_reset();
        s_axi_araddr[0 +: AW] = 25'h1ABCDEF;
        s_axi_arvalid = 2'b01; m_axi_arready = 1'b1; s_axi_rready = 2'b11;
        @(negedge clk); #1;
        check("rd_araddr", m_axi_araddr, 25'h1ABCDEF);
        check("rd_arready", s_axi_arready, 2'b01);
        @(negedge clk);
        s_axi_arvalid = '0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 16'h5A5A;
        #1;
        check("rd_rvalid", s_axi_rvalid, 2'b01);
        check("rd_rdata", s_axi_rdata, 16'h5A5A);
        check("rd_mrready", m_axi_rready, 1'b1);
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        #1;
        check("rd_done", {busy, s_axi_rvalid}, 3'b000);

        // Contention: both ports read continuously
        do_reset();
        s_axi_arvalid = 2'b11; m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; s_axi_rready = 2'b11;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        exp_order[0] = 2'b01; exp_order[1] = 2'b01; exp_order[2] = 2'b01; exp_order[3] = 2'b01;
`else
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
`endif
        n_got = 0;
        for (int c = 0; c < 40 && n_got < 4; c++) begin
            @(negedge clk); #1;
            if (m_axi_arvalid) begin
                order[n_got] = grant;
                n_got++;
            end
        end
        check("cont_count", n_got, 4);
        for (int i = 0; i < n_got; i++) check($sformatf("cont_grant%0d", i), order[i], exp_order[i]);

        // Same-port read and write together: read first
        do_reset();
        s_axi_arvalid = 2'b01; s_axi_awvalid = 2'b01; s_axi_wvalid = 2'b01;
        m_axi_arready = 1'b1; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        m_axi_rvalid = 1'b1; s_axi_rready = 2'b01;
        n_got = 0; drop_ar = 1'b0; drop_aw = 1'b0;
        for (int c = 0; c < 20 && n_got < 2; c++) begin
            @(negedge clk);
            if (drop_ar) s_axi_arvalid = '0;
            if (drop_aw) begin s_axi_awvalid = '0; s_axi_wvalid = '0; end
            #1;
            if (m_axi_arvalid) begin
                op_kind[n_got] = 1; op_grant[n_got] = grant; n_got++;
                if (s_axi_arready[0]) drop_ar = 1'b1;
            end else if (m_axi_awvalid) begin
                op_kind[n_got] = 2; op_grant[n_got] = grant; n_got++;
                if (s_axi_awready[0]) drop_aw = 1'b1;
            end
        end
        check("same_count", n_got, 2);
        if (n_got == 2) begin
            check("same_first_read", op_kind[0], 1);
            check("same_second_write", op_kind[1], 2);
            check("same_grants", {op_grant[0], op_grant[1]}, 4'b0101);
        end

        // Stalled rready on port 1 while port 0 waits
        do_reset();
        s_axi_araddr = {25'h0000B11, 25'h0000A00};
        s_axi_arvalid = 2'b10; m_axi_arready = 1'b1;
        @(negedge clk); #1;
        check("stall_issue_grant", grant, 2'b10);
        @(negedge clk);
        s_axi_arvalid = 2'b01; m_axi_rvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("stall_hold%0d", i), {grant, m_axi_arvalid, s_axi_rvalid}, {2'b10, 1'b0, 2'b10});
            @(negedge clk);
        end
        s_axi_rready = 2'b10;
        #1;
        check("stall_release_rready", m_axi_rready, 1'b1);
        @(negedge clk);
        s_axi_rready = '0; m_axi_rvalid = 1'b0;
        #1;
        check("stall_idle_grant", grant, 2'b00);
        @(negedge clk); #1;
        check("stall_next_grant", {grant, m_axi_arvalid, m_axi_araddr}, {2'b01, 1'b1, 25'h0000A00});

        // Reset during RDATA, after port 0 already completed one read
        do_reset();
        s_axi_arvalid = 2'b01; m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; s_axi_rready = 2'b01;
        repeat (4) @(negedge clk);
        s_axi_rready = '0;
        @(negedge clk); #1;
        check("rst_pre_rdata", {busy, s_axi_rvalid}, 3'b101);
        reset = 1'b1;
        #1;
        check("rst_mid_grant", grant, 2'b00);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_rvalid}, 8'b0);
        @(negedge clk);
        reset = 1'b0; s_axi_arvalid = 2'b11; m_axi_rvalid = 1'b0; m_axi_arready = 1'b0;
        @(negedge clk); #1;
        check("rst_last_restart", grant, 2'b01);

        // Randomized traffic against the transaction-level model
        do_reset();
        for (int i = 0; i < NP; i++) begin
            pend_rd[i] = 1'b0; pend_wr[i] = 1'b0; wdly[i] = 0;
            p_araddr[i] = '0; p_awaddr[i] = '0; p_wdata[i] = '0;
        end
        hs_ar = '0; hs_aw = '0;
        mo_owner = -1; mo_read = 1'b0; mo_data = 1'b0; mo_last = NP - 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) begin
                if (hs_ar[i]) pend_rd[i] = 1'b0;
                if (hs_aw[i]) pend_wr[i] = 1'b0;
                if (!pend_rd[i] && $urandom_range(0, 3) == 0) begin
                    pend_rd[i] = 1'b1; p_araddr[i] = AW'($urandom);
                end
                if (!pend_wr[i] && $urandom_range(0, 3) == 0) begin
                    pend_wr[i] = 1'b1; p_awaddr[i] = AW'($urandom);
                    p_wdata[i] = DW'($urandom); wdly[i] = $urandom_range(0, 2);
                end else if (pend_wr[i] && wdly[i] > 0) begin
                    wdly[i]--;
                end
                s_axi_arvalid[i] = pend_rd[i];
                s_axi_awvalid[i] = pend_wr[i];
                s_axi_wvalid[i]  = pend_wr[i] && (wdly[i] == 0);
                s_axi_araddr[i*AW +: AW] = p_araddr[i];
                s_axi_awaddr[i*AW +: AW] = p_awaddr[i];
                s_axi_wdata[i*DW +: DW]  = p_wdata[i];
                s_axi_rready[i] = ($urandom_range(0, 3) != 0);
            end
            m_axi_awready = $urandom_range(0, 1) == 1;
            m_axi_wready  = $urandom_range(0, 3) != 0;
            m_axi_arready = $urandom_range(0, 1) == 1;
            m_axi_rvalid  = $urandom_range(0, 2) != 0;
            m_axi_rdata   = DW'($urandom);
            #1;
            e_grant = '0; e_awr = '0; e_ar = '0; e_rv = '0;
            e_busy = 1'b0; e_awv = 1'b0; e_arv = 1'b0; e_rr = 1'b0;
            if (mo_owner >= 0) begin
                e_grant[mo_owner] = 1'b1;
                e_busy = 1'b1;
                if (!mo_data && !mo_read) begin
                    e_awv = 1'b1;
                    e_awr[mo_owner] = m_axi_awready && m_axi_wready;
                    check("rnd_awaddr", {m_axi_awaddr, m_axi_wdata}, {p_awaddr[mo_owner], p_wdata[mo_owner]});
                end else if (!mo_data) begin
                    e_arv = 1'b1;
                    e_ar[mo_owner] = m_axi_arready;
                    check("rnd_araddr", m_axi_araddr, p_araddr[mo_owner]);
                end else begin
                    e_rv[mo_owner] = m_axi_rvalid;
                    e_rr = s_axi_rready[mo_owner];
                end
            end
            check("rnd_ctrl",
                  {grant, busy, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready,
                   s_axi_awready, s_axi_wready, s_axi_arready, s_axi_rvalid},
                  {e_grant, e_busy, e_awv, e_awv, e_arv, e_rr, e_awr, e_awr, e_ar, e_rv});
            check("rnd_rdata", s_axi_rdata, m_axi_rdata);
            hs_ar = e_ar; hs_aw = e_awr;
            // Advance the model across the coming clock edge
            if (mo_owner < 0) begin
                req = s_axi_arvalid | (s_axi_awvalid & s_axi_wvalid);
                win = -1;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                for (int i = NP - 1; i >= 0; i--) if (req[i]) win = i;
`else
                for (int k = NP; k >= 1; k--) if (req[(mo_last + k) % NP]) win = (mo_last + k) % NP;
`endif
                if (win >= 0) begin
                    mo_owner = win; mo_read = s_axi_arvalid[win]; mo_data = 1'b0;
                end
            end else if (!mo_data && !mo_read) begin
                if (m_axi_awready && m_axi_wready) begin mo_last = mo_owner; mo_owner = -1; end
            end else if (!mo_data) begin
                if (m_axi_arready) mo_data = 1'b1;
            end else if (m_axi_rvalid && s_axi_rready[mo_owner]) begin
                mo_last = mo_owner; mo_owner = -1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single AXI-style slave port of the SDRAM controller between `NUM_PORTS` requesters, such as a video fetch engine and a CPU bridge. It sits directly in front of the controller. It accepts one read or write transaction at a time from the winning port, forwards it downstream, and returns read data only to the port that issued it. Arbitration is round-robin by default; fixed priority is selectable at compile time.

## Interface
Parameters:
- `ADDR_WIDTH`, 25: byte-free word address width, matching the controller.
- `DATA_WIDTH`, 16: data width.
- `NUM_PORTS`, 2: number of upstream requesters, 2..8. Index i occupies slice `[i*W +: W]` of each packed bus.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `s_axi_awaddr`  in  `NUM_PORTS*ADDR_WIDTH`  per-port write address.
- `s_axi_awvalid`  in  `NUM_PORTS`  per-port write address valid.
- `s_axi_awready`  out  `NUM_PORTS`  per-port write address ready.
- `s_axi_wdata`  in  `NUM_PORTS*DATA_WIDTH`  per-port write data.
- `s_axi_wvalid`  in  `NUM_PORTS`  per-port write data valid.
- `s_axi_wready`  out  `NUM_PORTS`  per-port write data ready.
- `s_axi_araddr`  in  `NUM_PORTS*ADDR_WIDTH`  per-port read address.
- `s_axi_arvalid`  in  `NUM_PORTS`  per-port read address valid.
- `s_axi_arready`  out  `NUM_PORTS`  per-port read address ready.
- `s_axi_rdata`  out  `DATA_WIDTH`  read data, broadcast to all ports.
- `s_axi_rvalid`  out  `NUM_PORTS`  per-port read data valid.
- `s_axi_rready`  in  `NUM_PORTS`  per-port read data ready.
- `m_axi_*`  awaddr/awvalid/awready/wdata/wvalid/wready/araddr/arvalid/arready/rdata/rvalid/rready  (`ADDR_WIDTH`, `DATA_WIDTH` or 1)  single downstream port to the controller, with mirrored directions.
- `grant`  out  `NUM_PORTS`  one-hot owner of the current transaction; 0 when idle.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Port i requests when `arvalid[i]`, or when both `awvalid[i]` and `wvalid[i]` are high. `awvalid` alone is not a request.
- Within one port, a read beats a write when both are pending.
- States:
  - IDLE: if any port requests, register the winner into `grant` and the op type (read or write), then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE, write:
    - `m_awvalid = m_wvalid = 1`; addr and data are muxed from the granted port.
    - `s_awready[g] = m_awready & m_wready` and `s_wready[g] = m_awready & m_wready`.
    - When both downstream handshakes complete in the same cycle, go to IDLE.
  - ISSUE, read:
    - `m_arvalid = 1`; `s_arready[g] = m_arready`.
    - On handshake, go to RDATA.
  - RDATA: `s_rvalid[g] = m_rvalid`; `m_rready = s_rready[g]`. On handshake, go to IDLE.
- Every ready and valid of a non-granted port, and every downstream valid outside the matching state, is 0.
- Downstream valids are driven only from registered state and never combinationally from an upstream valid. Upstream ports must hold valid and payload until accepted, per AXI rules.
- Round-robin:
  - `last` pointer resets to `NUM_PORTS-1`.
  - The search starts at `last+1` and wraps modulo `NUM_PORTS`.
  - `last` updates to the winner when the transaction completes, i.e. on the return to IDLE.
- A requester that drops valid before grant loses nothing. Behaviour if it drops valid after grant is undefined; this is a protocol violation.

## Timing
- Reset: state IDLE, `grant=0`, `busy=0`, all valids and readys 0, `last=NUM_PORTS-1`. `s_axi_rdata` follows `m_axi_rdata` combinationally.
- Arbitration latency is 1 cycle: a request seen in IDLE at edge N is driven downstream from cycle N+1.
- Back-to-back: after completion the block spends at least 1 cycle in IDLE, so a new grant is visible 1 cycle after the completing handshake.
- Simultaneous requests are resolved only by the IDLE decision. Requests arriving mid-transaction wait.
- Reset mid-transaction returns to IDLE immediately. The controller must be reset in the same cycle; the system guarantees this.

## Configuration
- `SDRAM_ARB_FIXED_PRIO_EN` defined: the lowest-index requesting port always wins, and `last` is unused.
- `SDRAM_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.

## Test plan
- Single write: port 1 writes addr 0x0000123, data 0xBEEF. Required: `grant=2'b10`; downstream sees 0x0000123/0xBEEF; `s_awready[1]` and `s_wready[1]` pulse in the same cycle; then `busy=0`.
- Single read: port 0 reads 0x1ABCDEF and the controller returns 0x5A5A. Required: only `s_rvalid[0]` rises, with `s_axi_rdata=0x5A5A`, and `s_rvalid[1]` stays 0.
- Contention: both ports read continuously for 4 transactions. Required grant order is 0,1,0,1 under round-robin, and 0,0,0,0 with `SDRAM_ARB_FIXED_PRIO_EN`.
- Same-port conflict: port 0 asserts arvalid and aw/wvalid together. Required: the read is issued first and the write follows in the next grant to port 0.
- Stalled rready: port 1 holds rready low for 10 cycles while port 0 requests. Required: `grant` stays 2'b10 and `m_arvalid` stays 0 until the port 1 rvalid/rready handshake completes.
- Reset during RDATA: required state IDLE, `grant=0`, `last=NUM_PORTS-1`, all `s_*ready` and `s_rvalid` 0 on the cycle after reset asserts.
